// File: rtl/fetch_req_tracker_pkg.sv
// Shared constants and helpers for the fetch request tracker and its queue.
package fetch_req_tracker_pkg;

    // Performance counters saturate when every bit equals this value.
    localparam bit CNT_SAT_BIT = 1'b1;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_MIS = 2;
    localparam int NUM_ERR = 3;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_req_tracker_if.sv
// Fetch request / response bus observed by the tracker.
interface fetch_req_tracker_if #(
    parameter int ADDRESS_BITS = 12
);
    logic                    req_valid;
    logic [ADDRESS_BITS-1:0] req_addr;
    logic                    resp_valid;
    logic [ADDRESS_BITS-1:0] resp_addr;

    modport master (output req_valid, req_addr, resp_valid, resp_addr);
    modport slave  (input  req_valid, req_addr, resp_valid, resp_addr);
endinterface

// File: rtl/fetch_req_tracker_queue.sv
// In-order circular queue of outstanding request addresses; a push into a
// full queue without a pop drops the oldest entry.
module req_queue
    import fetch_req_tracker_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_addr,
    output logic [AW-1:0] o_head,
    output logic [PW:0]   o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_drop
);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          w_inc;
    logic          w_dec;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_drop  = i_push && o_full && !i_pop;

    // Push+pop and drop-oldest both leave occupancy unchanged.
    assign w_inc = i_push && !i_pop && !o_full;
    assign w_dec = i_pop && !i_push;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_tail <= r_tail + PW'(1);
            if (i_pop || o_drop)
                r_head <= r_head + PW'(1);
            if (w_inc)
                r_count <= r_count + (PW+1)'(1);
            else if (w_dec)
                r_count <= r_count - (PW+1)'(1);
        end
    end

    // When full, the tail slot is the head slot; the head is read before the write lands.
    always_ff @(posedge clock) begin
        if (i_push)
            r_mem[r_tail] <= i_addr;
    end

endmodule

// File: rtl/fetch_req_tracker.sv
// Tracks outstanding fetch requests, checks in-order responses, keeps sticky
// error state, saturating performance counters and an end-of-run marker.
module fetch_req_tracker
    import fetch_req_tracker_pkg::*;
#(
    parameter int          ADDRESS_BITS = 12,
    parameter int          DEPTH        = 4,
    parameter int          COUNT_BITS   = 32,
    parameter int unsigned END_PC       = 'h0B0
) (
    input  logic                      clock,
    input  logic                      reset,
    fetch_req_tracker_if.slave        bus,
    input  logic [ADDRESS_BITS-1:0]   monitor_pc,
    input  logic                      clear_errors,
    output logic [ptr_w(DEPTH):0]     outstanding,
    output logic                      full,
    output logic                      empty,
    output logic                      err_overflow,
    output logic                      err_underflow,
    output logic                      err_mismatch,
    output logic [ADDRESS_BITS-1:0]   err_expected,
    output logic [ADDRESS_BITS-1:0]   err_actual,
    output logic [COUNT_BITS-1:0]     cycle_count,
    output logic [COUNT_BITS-1:0]     req_count,
    output logic [COUNT_BITS-1:0]     resp_count,
    output logic [COUNT_BITS-1:0]     full_cycles,
    output logic                      done,
    output logic [COUNT_BITS-1:0]     done_cycles
);

    localparam logic [COUNT_BITS-1:0] CNT_MAX = {COUNT_BITS{CNT_SAT_BIT}};

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v,
                                                       input logic en);
        return (en && v != CNT_MAX) ? v + COUNT_BITS'(1) : v;
    endfunction

    logic [ADDRESS_BITS-1:0] w_head;
    logic                    w_pop;
    logic                    w_drop;
    logic [NUM_ERR-1:0]      w_new_err;
    logic [NUM_ERR-1:0]      r_err;
    logic [ADDRESS_BITS-1:0] r_err_expected;
    logic [ADDRESS_BITS-1:0] r_err_actual;
    logic [COUNT_BITS-1:0]   r_cycle_count;
    logic [COUNT_BITS-1:0]   r_req_count;
    logic [COUNT_BITS-1:0]   r_resp_count;
    logic [COUNT_BITS-1:0]   r_full_cycles;
    logic                    r_done;
    logic [COUNT_BITS-1:0]   r_done_cycles;

    // A response into an empty queue never pops, so a same-cycle request still lands.
    assign w_pop = bus.resp_valid && !empty;

    req_queue #(.AW(ADDRESS_BITS), .DEPTH(DEPTH)) u_queue (
        .clock   (clock),
        .reset   (reset),
        .i_push  (bus.req_valid),
        .i_pop   (w_pop),
        .i_addr  (bus.req_addr),
        .o_head  (w_head),
        .o_count (outstanding),
        .o_full  (full),
        .o_empty (empty),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_new_err          = '0;
        w_new_err[ERR_OVF] = w_drop;
        w_new_err[ERR_UNF] = bus.resp_valid && empty;
        w_new_err[ERR_MIS] = w_pop && (bus.resp_addr != w_head);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err          <= '0;
            r_err_expected <= '0;
            r_err_actual   <= '0;
        end else begin
            // A new error in the same cycle as a clear survives the clear.
            r_err <= (clear_errors ? '0 : r_err) | w_new_err;
            if (w_new_err[ERR_MIS] && (!r_err[ERR_MIS] || clear_errors)) begin
                r_err_expected <= w_head;
                r_err_actual   <= bus.resp_addr;
            end else if (clear_errors) begin
                r_err_expected <= '0;
                r_err_actual   <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
            r_req_count   <= '0;
            r_resp_count  <= '0;
            r_full_cycles <= '0;
            r_done        <= 1'b0;
            r_done_cycles <= '0;
        end else begin
            r_cycle_count <= sat_inc(r_cycle_count, 1'b1);
            r_req_count   <= sat_inc(r_req_count, bus.req_valid);
            r_resp_count  <= sat_inc(r_resp_count, bus.resp_valid);
            r_full_cycles <= sat_inc(r_full_cycles, full);
            if (!r_done && monitor_pc == ADDRESS_BITS'(END_PC)) begin
                r_done        <= 1'b1;
                r_done_cycles <= r_cycle_count;
            end
        end
    end

    assign err_overflow  = r_err[ERR_OVF];
    assign err_underflow = r_err[ERR_UNF];
    assign err_mismatch  = r_err[ERR_MIS];
    assign err_expected  = r_err_expected;
    assign err_actual    = r_err_actual;
    assign cycle_count   = r_cycle_count;
    assign req_count     = r_req_count;
    assign resp_count    = r_resp_count;
    assign full_cycles   = r_full_cycles;
    assign done          = r_done;
    assign done_cycles   = r_done_cycles;

endmodule

// File: tb/tb_fetch_req_tracker.sv
// Directed-vector bench for fetch_req_tracker with hand-computed expectations.
module tb_fetch_req_tracker;
    localparam int AW = 12;
    localparam int CB = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] monitor_pc;
    logic          clear_errors;
    logic [2:0]    outstanding;
    logic          full, empty;
    logic          err_overflow, err_underflow, err_mismatch;
    logic [AW-1:0] err_expected, err_actual;
    logic [CB-1:0] cycle_count, req_count, resp_count, full_cycles, done_cycles;
    logic          done;

    int n_chk = 0;
    int n_err = 0;

    fetch_req_tracker_if #(.ADDRESS_BITS(AW)) bus ();

    fetch_req_tracker #(
        .ADDRESS_BITS(AW), .DEPTH(4), .COUNT_BITS(CB), .END_PC('h0B0)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus.slave),
        .monitor_pc(monitor_pc), .clear_errors(clear_errors),
        .outstanding(outstanding), .full(full), .empty(empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_mismatch(err_mismatch), .err_expected(err_expected),
        .err_actual(err_actual), .cycle_count(cycle_count),
        .req_count(req_count), .resp_count(resp_count),
        .full_cycles(full_cycles), .done(done), .done_cycles(done_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on falling edges; each cyc() crosses one rising edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic req(input logic [AW-1:0] a);
        bus.req_valid = 1'b1; bus.req_addr = a;
        cyc(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic resp(input logic [AW-1:0] a);
        bus.resp_valid = 1'b1; bus.resp_addr = a;
        cyc(1);
        bus.resp_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        cyc(1);
        clear_errors = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_outstanding"}, 32'(outstanding), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_errs"}, {29'd0, err_overflow, err_underflow, err_mismatch}, 0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; monitor_pc = '0; clear_errors = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0;
        bus.resp_valid = 1'b0; bus.resp_addr = '0;
        #1;
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_errs", {29'd0, err_overflow, err_underflow, err_mismatch}, 0);
        chk("rst_cycle_count", 32'(cycle_count), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;

        // in-order responses
        req(12'h000); req(12'h004); req(12'h008);
        chk("io_outstanding", 32'(outstanding), 3);
        resp(12'h000); resp(12'h004); resp(12'h008);
        chk("io_errs", {29'd0, err_overflow, err_underflow, err_mismatch}, 0);
        chk("io_req_count", 32'(req_count), 3);
        chk("io_resp_count", 32'(resp_count), 3);
        chk("io_empty", 32'(empty), 1);

        // mismatch capture, then clear
        req(12'h010); resp(12'h014);
        chk("mis_flag", 32'(err_mismatch), 1);
        chk("mis_expected", 32'(err_expected), 'h010);
        chk("mis_actual", 32'(err_actual), 'h014);
        chk("mis_empty", 32'(empty), 1);
        pulse_clear();
        chk("mis_clr_flag", 32'(err_mismatch), 0);
        chk("mis_clr_expected", 32'(err_expected), 0);
        chk("mis_clr_actual", 32'(err_actual), 0);

        // overflow drops the oldest entry
        for (int i = 0; i < 5; i++) req(AW'(i * 4));
        chk("ovf_flag", 32'(err_overflow), 1);
        chk("ovf_outstanding", 32'(outstanding), 4);
        chk("ovf_full", 32'(full), 1);
        pulse_clear();
        chk("ovf_clr", 32'(err_overflow), 0);
        resp(12'h004);
        chk("ovf_head_match", 32'(err_mismatch), 0);
        chk("ovf_after_pop", 32'(outstanding), 3);

        // reset with entries outstanding
        do_reset("midrst");

        // full with simultaneous request and response
        req(12'h000); req(12'h004); req(12'h008); req(12'h00C);
        chk("fs_full", 32'(full), 1);
        chk("fs_full_cycles0", 32'(full_cycles), 0);
        bus.resp_valid = 1'b1; bus.resp_addr = 12'h000;
        req(12'h020);
        bus.resp_valid = 1'b0;
        chk("fs_errs", {29'd0, err_overflow, err_underflow, err_mismatch}, 0);
        chk("fs_outstanding", 32'(outstanding), 4);
        chk("fs_full_cycles1", 32'(full_cycles), 1);
        resp(12'h004);
        chk("fs_next_head", 32'(err_mismatch), 0);
        chk("fs_outstanding2", 32'(outstanding), 3);
        chk("fs_full_cycles2", 32'(full_cycles), 2);

        do_reset("rst2");

        // underflow, clear, and underflow with a same-cycle push
        resp(12'h030);
        chk("unf_flag", 32'(err_underflow), 1);
        chk("unf_outstanding", 32'(outstanding), 0);
        pulse_clear();
        chk("unf_clr", 32'(err_underflow), 0);
        bus.resp_valid = 1'b1; bus.resp_addr = 12'h044;
        req(12'h040);
        bus.resp_valid = 1'b0;
        chk("unf_push_flag", 32'(err_underflow), 1);
        chk("unf_push_outstanding", 32'(outstanding), 1);
        chk("unf_push_nomis", 32'(err_mismatch), 0);

        // clear coinciding with a new mismatch: the new error wins
        clear_errors = 1'b1;
        resp(12'h099);
        clear_errors = 1'b0;
        chk("cw_mis", 32'(err_mismatch), 1);
        chk("cw_unf_cleared", 32'(err_underflow), 0);
        chk("cw_expected", 32'(err_expected), 'h040);
        chk("cw_actual", 32'(err_actual), 'h099);

        do_reset("rst3");

        // end of run at cycle 57, later matches ignored, counter saturation
        cyc(57);
        chk("done_pre_cycle", 32'(cycle_count), 57);
        chk("done_pre", 32'(done), 0);
        monitor_pc = 12'h0B0;
        cyc(1);
        monitor_pc = '0;
        chk("done_set", 32'(done), 1);
        chk("done_cycles", 32'(done_cycles), 57);
        cyc(3);
        monitor_pc = 12'h0B0;
        cyc(1);
        monitor_pc = '0;
        chk("done_hold", 32'(done), 1);
        chk("done_cycles_hold", 32'(done_cycles), 57);
        cyc(10);
        chk("cycle_sat", 32'(cycle_count), 63);
        req(12'h100); resp(12'h100);
        chk("post_done_queue", 32'(empty), 1);
        chk("post_done_errs", {29'd0, err_overflow, err_underflow, err_mismatch}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_req_tracker.md
FETCH_REQ_TRACKER -- requirements
Module: fetch_req_tracker

Interface
REQ-001 The block SHALL have parameter ADDRESS_BITS, default 12: request/response address width.
REQ-002 The block SHALL have parameter DEPTH, default 4: maximum outstanding requests; a power of two, at least 2.
REQ-003 The block SHALL have parameter COUNT_BITS, default 32: width of every performance counter.
REQ-004 The block SHALL have parameter END_PC, default 12'h0B0: end-of-run PC value.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req_valid / req_addr, input, 1 / ADDRESS_BITS: fetch request issued this cycle.
REQ-008 The block SHALL have port resp_valid / resp_addr, input, 1 / ADDRESS_BITS: response returned this cycle.
REQ-009 The block SHALL have port monitor_pc, input, ADDRESS_BITS: PC observed in the memory stage.
REQ-010 The block SHALL have port clear_errors, input, 1 bit: synchronous clear of the sticky error state.
REQ-011 The block SHALL have ports outstanding (log2(DEPTH)+1 bits), full and empty, all outputs: queue occupancy.
REQ-012 The block SHALL have ports err_overflow, err_underflow and err_mismatch, outputs, 1 bit each: sticky error flags.
REQ-013 The block SHALL have ports err_expected and err_actual, outputs, ADDRESS_BITS each: the addresses captured at the first mismatch.
REQ-014 The block SHALL have ports cycle_count, req_count, resp_count and full_cycles, outputs, COUNT_BITS each: performance counters.
REQ-015 The block SHALL have ports done (output, 1 bit) and done_cycles (output, COUNT_BITS): end-of-run flag and the cycle count at which it was set.

Function
REQ-016 The block SHALL hold request addresses in an in-order circular queue of DEPTH entries, with head and tail pointers that wrap modulo DEPTH.
REQ-017 On req_valid with the queue not full, the block SHALL write req_addr at the tail and increment the tail.
REQ-018 On resp_valid with the queue not empty, the block SHALL compare resp_addr with the head entry, then pop the head.
REQ-019 On a mismatch, the block SHALL still pop, set err_mismatch, and capture err_expected (head entry) and err_actual (resp_addr), but only if err_mismatch was previously 0.
REQ-020 On resp_valid with the queue empty, the block SHALL set err_underflow and leave the queue unchanged, even if req_valid is also high that cycle; the request SHALL still be pushed.
REQ-021 On req_valid with the queue full and no response, the block SHALL set err_overflow, discard the oldest entry, push req_addr, and leave outstanding at DEPTH.
REQ-022 On simultaneous req and resp with the queue full, the block SHALL pop first, then push; this is not an error.
REQ-023 On simultaneous req and resp with the queue partially full, the block SHALL leave outstanding unchanged.
REQ-024 The block SHALL drive full = (outstanding == DEPTH) and empty = (outstanding == 0) combinationally from registered state.
REQ-025 Every error flag and counter SHALL reflect an event one cycle after the event's rising edge.
REQ-026 Error flags SHALL be sticky until reset or clear_errors; clear_errors SHALL also zero err_expected and err_actual.
REQ-027 If clear_errors coincides with a new error, the new error SHALL win, and the flag SHALL be 1 on the next cycle.
REQ-028 cycle_count SHALL increment every cycle.
REQ-029 req_count SHALL increment on each req_valid.
REQ-030 resp_count SHALL increment on each resp_valid.
REQ-031 full_cycles SHALL increment on each cycle in which full is 1.
REQ-032 All four counters SHALL saturate at all-ones and not wrap.
REQ-033 When monitor_pc == END_PC and done is 0, the block SHALL set done and load done_cycles with the current cycle_count.
REQ-034 done SHALL then stay at 1; later matches SHALL NOT update done_cycles.
REQ-035 The queue and error logic SHALL keep operating after done is set.

Reset
REQ-036 While reset is low, the block SHALL asynchronously clear the pointers, outstanding, all error flags, err_expected, err_actual, all counters, done and done_cycles; empty SHALL be 1 and full SHALL be 0.
REQ-037 Assertion of reset mid-operation SHALL abandon all outstanding entries without raising any error.
REQ-038 The first event after reset release SHALL be processed on the first rising edge with reset high.

Structure
REQ-039 A shared package SHALL hold the counter-saturation constant, the pointer-width function log2(DEPTH), and the error-flag index constants.
REQ-040 The queue SHALL be one sub-module, req_queue (push, pop, drop-oldest, head, occupancy); the checker, counters and done logic SHALL sit in the top level.

Verification
REQ-041 The bench SHALL cover in-order responses: requests 0x000, 0x004, 0x008, then matching responses -> no errors; req_count and resp_count = 3; ends empty.
REQ-042 The bench SHALL cover mismatch: request 0x010, response 0x014 -> err_mismatch = 1, err_expected = 0x010, err_actual = 0x014; queue empty.
REQ-043 The bench SHALL cover overflow at DEPTH=4: five requests 0x0..0x10 with no response -> err_overflow = 1; head = 0x4; outstanding = 4.
REQ-044 The bench SHALL cover full with simultaneous request and response: req 0x20 and resp 0x0 -> no error; outstanding = 4; full_cycles increments.
REQ-045 The bench SHALL cover underflow with clear: response while empty -> err_underflow = 1; pulse clear_errors -> 0; reset mid-queue -> outstanding = 0 with no error.
REQ-046 The bench SHALL cover end of run: monitor_pc = 0x0B0 at cycle 57 -> done = 1, done_cycles = 57; a later 0x0B0 leaves done_cycles at 57.
